// File: rtl/cam_i2c_arbiter.sv
// Round-robin arbiter that shares one camera I2C write engine between two requesters.
// Optional send-to-completion timeout abort: define I2C_ARB_TIMEOUT_EN.

module cam_i2c_arbiter #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  logic        clk400,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  slave0,
    input  logic [7:0]  slave1,
    input  logic [15:0] reg0,
    input  logic [15:0] reg1,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        busy,
    output logic        eng_send,
    output logic [7:0]  eng_slave,
    output logic [15:0] eng_reg,
    output logic [7:0]  eng_data,
    input  logic        eng_ready,
    input  logic        eng_nack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_owner;
    logic        r_rr;
    logic        r_err;
    logic        r_send;
    logic [7:0]  r_slave;
    logic [15:0] r_reg;
    logic [7:0]  r_data;
    logic        w_go;
    logic        w_winner;
    logic        w_timeout;
    logic        w_busy;
    logic        w_rel;

    assign w_go     = eng_ready & (req0 | req1);
    assign w_winner = (req0 & req1) ? r_rr : req1;

    // The counter must be able to hold TIMEOUT_CYC; an empty marker block flags misuse.
    if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYC)) begin : g_to_w_too_small
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic            w_waiting;

    assign w_waiting = (r_state == S_WAIT_BUSY) | (r_state == S_WAIT_DONE);
    assign w_timeout = w_waiting & (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk400) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_to_cnt <= '0;
        end else if (w_waiting) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk400) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (w_go) w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (w_timeout)       w_next = S_RELEASE;
                else if (!eng_ready) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (w_timeout || eng_ready) w_next = S_RELEASE;
            S_RELEASE:   w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk400) begin
        if (reset) begin
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
            r_err   <= 1'b0;
            r_send  <= 1'b0;
            r_slave <= '0;
            r_reg   <= '0;
            r_data  <= '0;
        end else begin
            r_send <= (r_state == S_ISSUE);
            if (r_state == S_IDLE && w_go) begin
                r_owner <= w_winner;
                r_err   <= 1'b0;
                r_slave <= w_winner ? slave1 : slave0;
                r_reg   <= w_winner ? reg1   : reg0;
                r_data  <= w_winner ? data1  : data0;
            end
            if (r_state == S_WAIT_DONE && eng_ready) begin
                r_err <= eng_nack;
            end
            // A timeout overrides whatever NACK the engine reports.
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (r_state == S_RELEASE) begin
                r_rr <= ~r_owner;
            end
        end
    end

    assign w_busy = (r_state != S_IDLE);
    assign w_rel  = (r_state == S_RELEASE);

    always_comb begin
        busy  = w_busy;
        gnt0  = w_busy & ~r_owner;
        gnt1  = w_busy & r_owner;
        done0 = w_rel & ~r_owner;
        done1 = w_rel & r_owner;
        err0  = w_rel & ~r_owner & r_err;
        err1  = w_rel & r_owner & r_err;
    end

    assign eng_send  = r_send;
    assign eng_slave = r_slave;
    assign eng_reg   = r_reg;
    assign eng_data  = r_data;

endmodule

// File: tb/tb_cam_i2c_arbiter.sv
// Bench for cam_i2c_arbiter: engine model, transaction-level reference model,
// per-cycle compare, plus directed literal checks.

module tb_cam_i2c_arbiter;

    localparam int TO = 64;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk400 = 1'b0;
    logic        reset  = 1'b1;
    logic        req0   = 1'b0;
    logic        req1   = 1'b0;
    logic [7:0]  slave0 = '0;
    logic [7:0]  slave1 = '0;
    logic [15:0] reg0   = '0;
    logic [15:0] reg1   = '0;
    logic [7:0]  data0  = '0;
    logic [7:0]  data1  = '0;
    logic        eng_ready = 1'b1;
    logic        eng_nack  = 1'b0;
    logic        gnt0, gnt1, done0, done1, err0, err1, busy, eng_send;
    logic [7:0]  eng_slave;
    logic [15:0] eng_reg;
    logic [7:0]  eng_data;

    always #5 clk400 = ~clk400;

    cam_i2c_arbiter #(
        .TIMEOUT_CYC(TO),
        .TO_W       (7)
    ) dut (
        .clk400   (clk400),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .slave0   (slave0),
        .slave1   (slave1),
        .reg0     (reg0),
        .reg1     (reg1),
        .data0    (data0),
        .data1    (data1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .err0     (err0),
        .err1     (err1),
        .busy     (busy),
        .eng_send (eng_send),
        .eng_slave(eng_slave),
        .eng_reg  (eng_reg),
        .eng_data (eng_data),
        .eng_ready(eng_ready),
        .eng_nack (eng_nack)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // engine model controls
    bit e_active   = 1'b0;
    bit e_hang     = 1'b0;
    bit e_nack_cfg = 1'b0;
    bit ext_hold   = 1'b0;
    int e_cnt      = 0;
    int e_lat      = 20;

    // reference model: who owns the engine, and when the done pulse is due
    int          cyc       = 0;
    int          m_own     = -1;
    int          m_age     = 0;
    int          m_rr      = 0;
    int          m_done_at = -1;
    bit          m_err     = 1'b0;
    bit          m_low     = 1'b0;
    logic [7:0]  m_sl      = '0;
    logic [15:0] m_rg      = '0;
    logic [7:0]  m_dt      = '0;

    int n_done0 = 0;
    int n_done1 = 0;
    bit p_g0    = 1'b0;
    bit p_g1    = 1'b0;
    int order[$];

    always @(negedge clk400) begin : sim
        logic [7:0] e_fl;
        logic [7:0] a_fl;
        logic       d0;
        logic       d1;
        int         w;
        // engine
        if (e_active) begin
            if (!e_hang) begin
                e_cnt--;
                if (e_cnt <= 0) begin
                    e_active = 1'b0;
                    eng_nack = e_nack_cfg;
                end
            end
        end else if (eng_send) begin
            e_active = 1'b1;
            e_cnt    = e_lat;
            eng_nack = 1'b0;
        end
        eng_ready = !(e_active || ext_hold);
        // compare
        d0   = (m_own == 0) && (cyc == m_done_at);
        d1   = (m_own == 1) && (cyc == m_done_at);
        e_fl = {m_own == 0, m_own == 1, m_own >= 0, (m_own >= 0) && (m_age == 1),
                d0, d1, d0 && m_err, d1 && m_err};
        a_fl = {gnt0, gnt1, busy, eng_send, done0, done1, err0, err1};
        chk("ctl_flags", 64'(a_fl), 64'(e_fl));
        chk("eng_fields", 64'({eng_slave, eng_reg, eng_data}), 64'({m_sl, m_rg, m_dt}));
        if (done0) n_done0++;
        if (done1) n_done1++;
        if (gnt0 && !p_g0) order.push_back(0);
        if (gnt1 && !p_g1) order.push_back(1);
        p_g0 = gnt0;
        p_g1 = gnt1;
        // model update with the inputs the DUT samples at the next edge
        if (reset) begin
            m_own = -1; m_rr = 0; m_done_at = -1;
            m_sl = '0; m_rg = '0; m_dt = '0;
        end else if (m_own < 0) begin
            if (eng_ready && (req0 || req1)) begin
                w = (req0 && req1) ? m_rr : (req1 ? 1 : 0);
                m_own = w; m_age = 0; m_done_at = -1; m_low = 0; m_err = 0;
                m_sl = w ? slave1 : slave0;
                m_rg = w ? reg1 : reg0;
                m_dt = w ? data1 : data0;
            end
        end else begin
            if (cyc == m_done_at) begin
                m_rr  = 1 - m_own;
                m_own = -1;
            end else if (m_done_at < 0 && m_age >= 1) begin
                if (TO_EN && m_age == TO) begin
                    m_done_at = cyc + 1; m_err = 1'b1;
                end else if (m_low && eng_ready) begin
                    m_done_at = cyc + 1; m_err = eng_nack;
                end else if (!eng_ready) begin
                    m_low = 1'b1;
                end
            end
            m_age++;
        end
        cyc++;
    end

    task automatic wait_done(input int side, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk400); #1;
            if ((side == 0) ? done0 : done1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_send(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk400); #1;
            if (eng_send) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk400);
        #1 reset = 1'b0;
    endtask

    task automatic requester(input int side, input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (side == 0) begin
                slave0 = 8'h10; reg0 = 16'h0100 + 16'(i); data0 = 8'(i); req0 = 1'b1;
            end else begin
                slave1 = 8'h36; reg1 = 16'h3500 + 16'(i); data1 = 8'h80 + 8'(i); req1 = 1'b1;
            end
            wait_done(side, 200, ok);
            if (side == 0) begin
                chk("alt_done0_seen", 64'(ok), 64'd1);
                req0 = 1'b0;
            end else begin
                chk("alt_done1_seen", 64'(ok), 64'd1);
                req1 = 1'b0;
            end
            repeat (2) @(posedge clk400);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        bit ok;
        int b0, b1, k;
        int exp_order[4] = '{0, 1, 0, 1};
        // reset held 3 cycles with req0 pending
        slave0 = 8'h10; reg0 = 16'h0100; data0 = 8'h01; req0 = 1'b1;
        repeat (3) @(posedge clk400);
        #1;
        chk("reset_flags", 64'({gnt0, gnt1, busy, eng_send, done0, done1, err0, err1}), 64'd0);
        chk("reset_fields", 64'({eng_slave, eng_reg, eng_data}), 64'd0);
        reset = 1'b0;
        @(posedge clk400); #1;
        chk("first_gnt0", 64'({gnt0, eng_send}), 64'b10);
        @(posedge clk400); #1;
        chk("first_send", 64'(eng_send), 64'd1);
        chk("first_fields", 64'({eng_slave, eng_reg, eng_data}), 64'h10_0100_01);
        @(posedge clk400); #1;
        chk("send_one_cycle", 64'(eng_send), 64'd0);
        wait_done(0, 100, ok);
        chk("first_done0", 64'({ok, err0, done1}), 64'b100);
        req0 = 1'b0;
        repeat (2) @(posedge clk400);
        #1;

        // both requesting: strict alternation
        do_reset();
        order.delete();
        b0 = n_done0; b1 = n_done1;
        fork
            requester(0, 2);
            requester(1, 2);
        join
        chk("alt_order_len", 64'(order.size()), 64'd4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk("alt_order", 64'(order[i]), 64'(exp_order[i]));
        chk("alt_done0_cnt", 64'(n_done0 - b0), 64'd2);
        chk("alt_done1_cnt", 64'(n_done1 - b1), 64'd2);

        // NACK on a req1 transaction
        e_nack_cfg = 1'b1;
        slave1 = 8'h10; reg1 = 16'h0103; data1 = 8'h11; req1 = 1'b1;
        wait_done(1, 100, ok);
        chk("nack_done1", 64'({ok, err1, done0, err0}), 64'b1100);
        chk("nack_fields", 64'({eng_slave, eng_reg, eng_data}), 64'h10_0103_11);
        req1 = 1'b0;
        e_nack_cfg = 1'b0;
        repeat (2) @(posedge clk400);
        #1;

        // engine not ready: requests must wait
        ext_hold = 1'b1;
        @(posedge clk400); #1;
        slave0 = 8'h20; reg0 = 16'h0200; data0 = 8'h22; req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk400); #1;
            chk("hold_no_gnt", 64'({gnt0, gnt1, eng_send}), 64'd0);
        end
        ext_hold = 1'b0;
        @(posedge clk400); #1;
        chk("hold_gnt_after", 64'(gnt0), 64'd1);
        wait_done(0, 100, ok);
        chk("hold_done0", 64'({ok, err0}), 64'b10);
        req0 = 1'b0;
        repeat (2) @(posedge clk400);
        #1;

        // reset during WAIT_DONE aborts silently
        slave0 = 8'h30; reg0 = 16'h0300; data0 = 8'h33; req0 = 1'b1;
        wait_send(20, ok);
        chk("rst_send_seen", 64'(ok), 64'd1);
        repeat (5) @(posedge clk400);
        #1 reset = 1'b1;
        @(posedge clk400); #1;
        chk("rst_idle", 64'({gnt0, busy, done0}), 64'd0);
        reset = 1'b0; req0 = 1'b0;
        b0 = n_done0;
        repeat (30) @(posedge clk400);
        #1;
        chk("rst_no_done", 64'(n_done0 - b0), 64'd0);
        slave1 = 8'h36; reg1 = 16'h3600; data1 = 8'h44; req1 = 1'b1;
        wait_done(1, 100, ok);
        chk("rst_then_req1", 64'({ok, err1}), 64'b10);
        req1 = 1'b0;
        repeat (2) @(posedge clk400);
        #1;

`ifdef I2C_ARB_TIMEOUT_EN
        // hung engine: timeout abort, then no grants until ready returns
        e_hang = 1'b1;
        slave0 = 8'h50; reg0 = 16'h0500; data0 = 8'h55; req0 = 1'b1;
        wait_send(20, ok);
        chk("to_send_seen", 64'(ok), 64'd1);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk400); #1;
            if (done0) begin
                k = i;
                break;
            end
        end
        chk("to_latency", 64'(k), 64'(TO));
        chk("to_err0", 64'({done0, err0}), 64'b11);
        req0 = 1'b0;
        @(posedge clk400); #1;
        slave1 = 8'h60; reg1 = 16'h0600; data1 = 8'h66; req1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk400); #1;
            chk("to_blocked", 64'({gnt0, gnt1}), 64'd0);
        end
        e_hang = 1'b0; e_cnt = 1;
        wait_done(1, 100, ok);
        chk("to_recover", 64'({ok, err1}), 64'b10);
        req1 = 1'b0;
        repeat (2) @(posedge clk400);
        #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_i2c_arbiter.md
Name: cam_i2c_arbiter

Overview:
- Shares one camera I2C register-write engine between two requesters: camera-0 and camera-1 init sequencers, or an init sequencer and a runtime exposure/gain controller.
- Arbitrates round-robin, latches the winner's transaction, pulses the engine's send strobe and tracks engine ready to completion.
- Returns a done/error pulse to the owning requester.
- Sits between the per-camera sequencers and the single engine instance on the 400 kHz I2C clock domain.

Parameters:
- TIMEOUT_CYC, 4096: clk400 cycles allowed from send strobe to engine completion before abort (used only with the optional feature).
- TO_W, 13: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk400  in  1  I2C-rate clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  requester N has a pending write; held high with fields stable until doneN
- slave0 / slave1  in  8  requester N I2C slave address
- reg0 / reg1  in  16  requester N register address
- data0 / data1  in  8  requester N write data
- gnt0 / gnt1  out  1  level; requester N owns the engine
- done0 / done1  out  1  1-cycle pulse; requester N transaction finished
- err0 / err1  out  1  valid with doneN; 1 = NACK or timeout
- busy  out  1  high in any state other than IDLE
- eng_send  out  1  1-cycle start strobe to the engine
- eng_slave  out  8  latched slave address
- eng_reg  out  16  latched register address
- eng_data  out  8  latched write data
- eng_ready  in  1  engine idle level; low while a transfer runs
- eng_nack  in  1  engine NACK flag; sampled when eng_ready returns high

Behaviour:
- Reset (synchronous, active-high) sets these values:
  - state IDLE; gnt*, done*, err*, eng_send, busy all 0.
  - eng_slave, eng_reg, eng_data all 0.
  - rr_ptr = 0 (requester 0 has priority on the next tie); timeout counter 0.
- Reset mid-transfer aborts silently: no done pulse. The engine is not reset by this block.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RELEASE.
- IDLE:
  - Advances only if eng_ready=1 and req0|req1.
  - With a single request, that requester wins.
  - With both requesting, the winner is rr_ptr.
  - On win: latch the winner's slave/reg/data into eng_*, set its gnt, go ISSUE.
  - With eng_ready=0, stay in IDLE regardless of requests.
- ISSUE: eng_send=1 for exactly one cycle; clear timeout counter; go WAIT_BUSY.
- WAIT_BUSY: wait for eng_ready=0 (engine accepted the strobe), then go WAIT_DONE.
- WAIT_DONE: on eng_ready=1, go RELEASE and capture err = eng_nack.
- RELEASE (one cycle):
  - doneN=1, errN=captured value; gntN drops at the end of this cycle.
  - rr_ptr = the other requester; go IDLE.
- Latency:
  - req high in IDLE with eng_ready=1 → gnt high next cycle → eng_send the cycle after.
  - Engine completion → doneN 1 cycle after eng_ready rises.
- Requester rules:
  - reqN must be low in the cycle after doneN. If it is still high, it is taken as a new transaction.
  - Field changes while gntN is high are ignored, because values were latched in IDLE.
- Fairness: back-to-back requests from both sides strictly alternate 0,1,0,1.
- The non-granted requester's done/err stay 0 throughout.
- eng_nack is ignored outside WAIT_DONE.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYC, go RELEASE with errN=1 regardless of eng_nack.
  - The next IDLE still waits for eng_ready=1, so a hung engine blocks further grants without deadlocking the requester.
- Undefined: no counter; WAIT_BUSY/WAIT_DONE wait indefinitely; err reflects eng_nack only.

Test Plan:
- Reset held 3 cycles with req0=1 → all outputs 0; after release, gnt0=1 next cycle, eng_send pulse one cycle later carrying slave0=0x10, reg0=0x0100, data0=0x01.
- req0 and req1 both high from IDLE, engine model busy 20 cycles each → grant order 0,1,0,1 over 4 transactions; exactly one done pulse per transaction to the correct side.
- Engine model asserts eng_nack=1 at completion for req1 transaction (slave 0x10, reg 0x0103, data 0x11) → done1=1, err1=1, done0/err0 stay 0.
- req0 raised while eng_ready=0 for 10 cycles → no gnt, no eng_send until eng_ready=1; then grant within 1 cycle.
- reset asserted during WAIT_DONE → next cycle state IDLE, gnt0=0, no done pulse; subsequent req1 is served normally.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC=64, engine never raises eng_ready → done0=1, err0=1 exactly 64 cycles after entering WAIT_BUSY; no further gnt until eng_ready=1.
